fetch_stage: RTL and testbench

Instruction-fetch front end of the 5-stage LoongArch pipeline: pre-IF address generation plus the IF stage. It issues requests on an SRAM-like instruction port and delivers `{inst, pc}` to ID over the valid/allowin handshake. It consumes ID's 34-bit branch bus to redirect fetch, and discards wrong-path returns so that only correct-path instructions reach ID.

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fs_discard_ctr.sv | 60 ++++++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared widths, reset address and branch-bus layout for the instruction-fetch front end.
// Decoding br_bus here keeps the field offsets in one place.
package fetch_stage_pkg;

   localparam int          FS_TO_DS_BUS_WD  = 64;
   localparam int          BR_BUS_WD        = 34;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
   localparam int          BR_CANCEL_BIT    = 33;
   localparam int          BR_TAKEN_BIT     = 32;

   typedef logic [1:0] discard_cnt_t;

   typedef struct packed {
      logic        cancel;
      logic        taken;
      logic [31:0] target;
   } br_bus_t;

   function automatic br_bus_t unpack_br_bus(input logic [BR_BUS_WD-1:0] bus);
      br_bus_t b;
      b.cancel = bus[BR_CANCEL_BIT];
      b.taken  = bus[BR_TAKEN_BIT];
      b.target = bus[31:0];
      return b;
   endfunction

endpackage

// File: rtl/fs_discard_ctr.sv
// Wrong-path bookkeeping for IF: counts returns still owed by squashed requests and
// remembers a redirect target until a correct-path request using it is accepted.
module fs_discard_ctr
   import fetch_stage_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         br_cancel,
   input  logic [31:0]  br_target,
   input  logic         fs_valid,
   input  logic         inst_buf_valid,
   input  logic         data_ok,
   input  logic         accept,
   input  logic         pend_valid,
   output discard_cnt_t discard_cnt,
   output logic         stale_accept,
   output logic         br_buf_valid,
   output logic [31:0]  br_buf_target
);

   logic         pend_stale;
   logic         live_data_ok;
   logic         inc_live;
   logic         inc_req;
   logic         dec;
   discard_cnt_t cnt_next;

   assign live_data_ok = data_ok && (discard_cnt == 2'd0);
   assign dec          = data_ok && (discard_cnt != 2'd0);
   // The live request is owed a return only if its word has neither arrived nor been buffered.
   assign inc_live     = br_cancel && fs_valid && !inst_buf_valid && !live_data_ok;
   assign inc_req      = accept && (br_cancel || pend_stale);
   assign stale_accept = accept && pend_stale;
   assign cnt_next     = discard_cnt + discard_cnt_t'(inc_live) + discard_cnt_t'(inc_req)
                         - discard_cnt_t'(dec);

   always_ff @(posedge clk) begin
      if (reset) begin
         discard_cnt  <= '0;
         pend_stale   <= 1'b0;
         br_buf_valid <= 1'b0;
      end else begin
         discard_cnt <= cnt_next;
         if (accept)
            pend_stale <= 1'b0;
         else if (br_cancel && pend_valid)
            pend_stale <= 1'b1;
         if (br_cancel)
            br_buf_valid <= 1'b1;
         else if (accept && !pend_stale)
            br_buf_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (br_cancel)
         br_buf_target <= br_target;
   end

endmodule

// File: rtl/fetch_stage.sv
// Pre-IF address generation and IF stage: issues word reads on the SRAM-like port and
// hands {inst, pc} to ID, squashing returns that belong to a cancelled path.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ds_allowin,
   input  logic [BR_BUS_WD-1:0]       br_bus,
   output logic                       fs_to_ds_valid,
   output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
   output logic                       inst_sram_req,
   output logic                       inst_sram_wr,
   output logic [1:0]                 inst_sram_size,
   output logic [3:0]                 inst_sram_wstrb,
   output logic [31:0]                inst_sram_addr,
   output logic [31:0]                inst_sram_wdata,
   input  logic                       inst_sram_addr_ok,
   input  logic                       inst_sram_data_ok,
   input  logic [31:0]                inst_sram_rdata
);

   br_bus_t      br;
   logic         br_stall;
   logic         fs_valid;
   logic         fs_ready_go;
   logic         fs_allowin;
   logic         live_data_ok;
   logic         ds_take;
   logic         accept;
   logic         stale_accept;
   logic         inst_buf_valid;
   logic         pend_valid;
   logic         br_buf_valid;
   logic [31:0]  br_buf_target;
   logic [31:0]  pend_addr;
   logic [31:0]  inst_buf;
   logic [31:0]  fs_pc;
   logic [31:0]  nextpc;
   logic [31:0]  fs_inst;
   discard_cnt_t discard_cnt;

   assign br       = unpack_br_bus(br_bus);
   assign br_stall = br.taken && !br.cancel;

   // Pre-IF: a request that has not been accepted keeps its address even across a redirect.
   assign nextpc         = br_buf_valid ? br_buf_target :
                           br.cancel    ? br.target     : fs_pc + 32'd4;
   assign inst_sram_req  = !reset && (pend_valid || (fs_allowin && !br_stall));
   assign inst_sram_addr = pend_valid ? pend_addr : nextpc;
   assign accept         = inst_sram_req && inst_sram_addr_ok;

   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'd2;
   assign inst_sram_wstrb = 4'h0;
   assign inst_sram_wdata = 32'h0;

   // IF stage control
   assign live_data_ok   = inst_sram_data_ok && (discard_cnt == 2'd0);
   assign fs_ready_go    = live_data_ok || inst_buf_valid;
   assign fs_allowin     = !fs_valid || (fs_ready_go && ds_allowin);
   assign fs_to_ds_valid = fs_valid && fs_ready_go && !br.cancel;
   assign ds_take        = fs_to_ds_valid && ds_allowin;

   assign fs_inst      = inst_buf_valid ? inst_buf :
                         fs_valid       ? inst_sram_rdata : 32'h0;
   assign fs_to_ds_bus = {fs_inst, fs_pc};

   always_ff @(posedge clk) begin
      if (reset) begin
         fs_valid       <= 1'b0;
         inst_buf_valid <= 1'b0;
         pend_valid     <= 1'b0;
         fs_pc          <= RESET_PC - 32'd4;
      end else begin
         if (br.cancel)
            fs_valid <= 1'b0;
         else if (accept && !stale_accept)
            fs_valid <= 1'b1;
         else if (ds_take)
            fs_valid <= 1'b0;

         if (accept && !br.cancel && !stale_accept)
            fs_pc <= inst_sram_addr;

         if (br.cancel || ds_take)
            inst_buf_valid <= 1'b0;
         else if (fs_valid && live_data_ok && !ds_allowin)
            inst_buf_valid <= 1'b1;

         pend_valid <= inst_sram_req && !inst_sram_addr_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (inst_sram_req && !pend_valid)
         pend_addr <= inst_sram_addr;
      if (fs_valid && live_data_ok && !inst_buf_valid)
         inst_buf <= inst_sram_rdata;
   end

   fs_discard_ctr u_discard (
      .clk            (clk),
      .reset          (reset),
      .br_cancel      (br.cancel),
      .br_target      (br.target),
      .fs_valid       (fs_valid),
      .inst_buf_valid (inst_buf_valid),
      .data_ok        (inst_sram_data_ok),
      .accept         (accept),
      .pend_valid     (pend_valid),
      .discard_cnt    (discard_cnt),
      .stale_accept   (stale_accept),
      .br_buf_valid   (br_buf_valid),
      .br_buf_target  (br_buf_target)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order SRAM model, directed cycle table, reset-mid-request
// sequence and a randomized run scored against the expected program-order pc stream.
module tb_fetch_stage;

   localparam logic [31:0] RC = 32'h1c00_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        ds_allowin;
   logic [33:0] br_bus;
   logic        fs_to_ds_valid;
   logic [63:0] fs_to_ds_bus;
   logic        inst_sram_req, inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic        aok_en, dok_en;

   int n_run = 0;
   int n_fail = 0;

   fetch_stage #(.RESET_PC(RC)) dut (
      .clk               (clk),
      .reset             (reset),
      .ds_allowin        (ds_allowin),
      .br_bus            (br_bus),
      .fs_to_ds_valid    (fs_to_ds_valid),
      .fs_to_ds_bus      (fs_to_ds_bus),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_wstrb   (inst_sram_wstrb),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hdead_beef;
   endfunction

   // In-order SRAM: accepted addresses queue up, data_ok pops the oldest when enabled.
   logic [31:0] fifo [8];
   logic [2:0]  wp, rp;
   logic [3:0]  fcnt;
   logic        push, pop;

   assign push              = inst_sram_req && inst_sram_addr_ok;
   assign pop               = inst_sram_data_ok;
   assign inst_sram_addr_ok = aok_en;
   assign inst_sram_data_ok = dok_en && (fcnt != 4'd0);
   assign inst_sram_rdata   = mem_word(fifo[rp]);

   always_ff @(posedge clk) begin
      if (reset) begin
         wp   <= '0;
         rp   <= '0;
         fcnt <= '0;
      end else begin
         if (push) begin
            fifo[wp] <= inst_sram_addr;
            wp       <= wp + 3'd1;
         end
         if (pop)
            rp <= rp + 3'd1;
         fcnt <= fcnt + 4'(push) - 4'(pop);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          aok, dok, allow, cancel, taken;
      logic [31:0] tgt;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_vld;
      logic [31:0] e_pc;
   } vec_t;

   function automatic vec_t mk(bit aok, bit dok, bit allow, bit cancel, bit taken,
                               int tgt, bit e_req, int e_addr, bit e_vld, int e_pc);
      vec_t v;
      v.aok = aok; v.dok = dok; v.allow = allow; v.cancel = cancel; v.taken = taken;
      v.tgt = RC + 32'(tgt);
      v.e_req = e_req; v.e_addr = RC + 32'(e_addr);
      v.e_vld = e_vld; v.e_pc = RC + 32'(e_pc);
      return v;
   endfunction

   task automatic drive(input bit aok, input bit dok, input bit allow,
                        input bit cancel, input bit taken, input logic [31:0] tgt);
      aok_en = aok; dok_en = dok; ds_allowin = allow;
      br_bus = {cancel, taken, tgt};
   endtask

   task automatic chk_out(input string tag, input bit e_req, input logic [31:0] e_addr,
                          input bit e_vld, input logic [31:0] e_pc);
      chk({tag, ".req"}, 64'(inst_sram_req), 64'(e_req));
      if (e_req) chk({tag, ".addr"}, 64'(inst_sram_addr), 64'(e_addr));
      chk({tag, ".valid"}, 64'(fs_to_ds_valid), 64'(e_vld));
      if (e_vld) chk({tag, ".bus"}, fs_to_ds_bus, {mem_word(e_pc), e_pc});
   endtask

   vec_t vt [23];

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc, br_tgt, pend_addr_prev;
      logic [63:0] bus_prev;
      bit          hs, hs_last, br_active, pend_prev, stall_prev, cancel_now, taken_now;
      int          stall_left, since_hs, n_hs;

      // aok dok allow cancel taken tgt | req addr valid pc   (offsets from RC)
      vt[0]  = mk(1,1,1,0,0,0,     1,'h000, 0,0);
      vt[1]  = mk(1,1,1,0,0,0,     1,'h004, 1,'h000);
      vt[2]  = mk(1,1,1,0,0,0,     1,'h008, 1,'h004);
      vt[3]  = mk(1,1,0,0,0,0,     0,0,     1,'h008);
      vt[4]  = mk(1,1,0,0,0,0,     0,0,     1,'h008);
      vt[5]  = mk(1,1,0,0,0,0,     0,0,     1,'h008);
      vt[6]  = mk(1,1,0,0,0,0,     0,0,     1,'h008);
      vt[7]  = mk(1,1,0,0,0,0,     0,0,     1,'h008);
      vt[8]  = mk(1,1,1,0,0,0,     1,'h00c, 1,'h008);
      vt[9]  = mk(1,0,1,0,0,0,     0,0,     0,0);
      vt[10] = mk(1,0,1,1,1,'h100, 0,0,     0,0);
      vt[11] = mk(0,1,1,0,0,0,     1,'h100, 0,0);
      vt[12] = mk(0,1,1,1,1,'h200, 1,'h100, 0,0);
      vt[13] = mk(1,0,1,0,0,0,     1,'h100, 0,0);
      vt[14] = mk(1,0,1,0,0,0,     1,'h200, 0,0);
      vt[15] = mk(0,1,1,0,0,0,     0,0,     0,0);
      vt[16] = mk(1,1,1,0,0,0,     1,'h204, 1,'h200);
      vt[17] = mk(1,1,0,0,1,'h300, 0,0,     1,'h204);
      vt[18] = mk(1,1,0,0,1,'h300, 0,0,     1,'h204);
      vt[19] = mk(1,1,0,0,1,'h300, 0,0,     1,'h204);
      vt[20] = mk(1,1,1,1,1,'h300, 1,'h300, 0,0);
      vt[21] = mk(1,1,1,0,0,0,     1,'h300, 0,0);
      vt[22] = mk(1,1,1,0,0,0,     1,'h304, 1,'h300);

      reset = 1'b1;
      drive(0, 0, 1, 0, 0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.req", 64'(inst_sram_req), 64'd0);
      chk("rst.valid", 64'(fs_to_ds_valid), 64'd0);
      chk("rst.bus", fs_to_ds_bus, {32'h0, RC - 32'd4});
      chk("rst.const", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
          {1'b0, 2'd2, 4'h0, 32'h0});

      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 23; i++) begin
         drive(vt[i].aok, vt[i].dok, vt[i].allow, vt[i].cancel, vt[i].taken, vt[i].tgt);
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_vld, vt[i].e_pc);
         @(posedge clk); #1;
      end

      // Reset arriving while a request waits for addr_ok.
      drive(0, 1, 1, 0, 0, 32'h0);
      @(negedge clk);
      chk_out("mid.pend", 1, RC + 32'h308, 1, RC + 32'h304);
      @(posedge clk); #1;
      drive(0, 0, 1, 0, 0, 32'h0);
      @(negedge clk);
      chk_out("mid.hold", 1, RC + 32'h308, 0, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid.rst_req", 64'(inst_sram_req), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid.after_valid", 64'(fs_to_ds_valid), 64'd0);
      chk("mid.after_bus", fs_to_ds_bus, {32'h0, RC - 32'd4});
      @(posedge clk); #1;
      reset = 1'b0;
      drive(1, 1, 1, 0, 0, 32'h0);
      @(negedge clk);
      chk_out("mid.refetch", 1, RC, 0, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_out("mid.first", 1, RC + 32'h4, 1, RC);

      // Randomized run: ID occasionally turns an accepted pc into a taken branch.
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      exp_pc = RC; hs_last = 0; br_active = 0; pend_prev = 0; stall_prev = 0;
      since_hs = 0; n_hs = 0; stall_left = 0; br_tgt = 32'h0; pend_addr_prev = 32'h0;
      bus_prev = 64'h0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         cancel_now = 0; taken_now = 0;
         ds_allowin = ($urandom_range(0, 4) != 0);
         if (!br_active && hs_last && $urandom_range(0, 5) == 0) begin
            br_active  = 1;
            stall_left = $urandom_range(0, 2);
            br_tgt     = RC + (32'($urandom_range(0, 1023)) << 2);
         end
         if (br_active) begin
            taken_now = 1;
            if (stall_left > 0) begin
               ds_allowin = 0;
               stall_left--;
            end else begin
               cancel_now = 1;
               br_active  = 0;
               exp_pc     = br_tgt;
            end
         end
         aok_en = ($urandom_range(0, 3) != 0);
         dok_en = ($urandom_range(0, 3) != 0);
         br_bus = {cancel_now, taken_now, (br_active || cancel_now) ? br_tgt : $urandom};

         @(negedge clk);
         if (pend_prev) chk("rnd.req_hold", {31'h0, inst_sram_req, inst_sram_addr},
                            {31'h0, 1'b1, pend_addr_prev});
         else if (taken_now && !cancel_now) chk("rnd.stall_req", 64'(inst_sram_req), 64'd0);
         if (stall_prev && !cancel_now) chk("rnd.stall_hold", {63'h0, fs_to_ds_valid} ^ fs_to_ds_bus,
                                           {63'h0, 1'b1} ^ bus_prev);
         hs = fs_to_ds_valid && ds_allowin;
         if (hs) begin
            chk("rnd.bus", fs_to_ds_bus, {mem_word(exp_pc), exp_pc});
            exp_pc = exp_pc + 32'd4;
            n_hs++;
            since_hs = 0;
         end else begin
            since_hs++;
         end
         if (since_hs > 300) begin
            chk("rnd.progress", 64'(since_hs), 64'd0);
            break;
         end
         pend_prev      = inst_sram_req && !inst_sram_addr_ok;
         pend_addr_prev = inst_sram_addr;
         stall_prev     = fs_to_ds_valid && !ds_allowin;
         bus_prev       = fs_to_ds_bus;
         hs_last        = hs;
         @(posedge clk); #1;
      end
      n_run++;
      if (n_hs < 500) begin
         n_fail++;
         $display("FAIL rnd.throughput: got %0d deliveries, expected at least 500", n_hs);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
